// File: rtl/muldiv_sched.sv
// -----------------------------------------------------------------------------
// muldiv_sched
//
// Sequencing and sharing controller in front of the combinational muldiv_unit.
// Two requesters are arbitrated round-robin. The winner's operands are captured
// and held stable for a fixed number of cycles so that the multiplier and
// divider paths can be closed as multicycle paths. The result is then
// registered and returned to the requester that issued the operation. Only
// one operation is in flight at a time.
//
// Parameters
//   XLEN        operand / result width
//   MUL_CYCLES  cycles the operands are held for MUL/MULH/MULHSU/MULHU (>= 1)
//   DIV_CYCLES  cycles the operands are held for DIV/DIVU/REM/REMU (>= 1)
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req{0,1}_valid_i / _ready_o       request handshake per requester
//   req{0,1}_op1_i, _op2_i, _funct3_i request operands and RV32M funct3
//   rsp{0,1}_valid_o / _ready_i       response handshake per requester
//   rsp_result_o                      registered result, shared by both ports
//   md_in1_o, md_in2_o, md_funct3_o   captured operands to muldiv_unit
//   md_opcode_o, md_funct7_o          constant R-type / MULDIV encodings
//   md_result_i                       muldiv_unit result
//   busy_o                            high whenever the FSM is not idle
//
// State table
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for a request; grants one requester combinationally
//   ST_EXEC | operands frozen, counting down the multicycle window
//   ST_RESP | result registered, waiting for the owner to take it
// -----------------------------------------------------------------------------
module muldiv_sched #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,

  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [XLEN-1:0] req0_op1_i,
  input  logic [XLEN-1:0] req0_op2_i,
  input  logic [2:0]      req0_funct3_i,

  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [XLEN-1:0] req1_op1_i,
  input  logic [XLEN-1:0] req1_op2_i,
  input  logic [2:0]      req1_funct3_i,

  output logic            rsp0_valid_o,
  input  logic            rsp0_ready_i,
  output logic            rsp1_valid_o,
  input  logic            rsp1_ready_i,
  output logic [XLEN-1:0] rsp_result_o,

  output logic [XLEN-1:0] md_in1_o,
  output logic [XLEN-1:0] md_in2_o,
  output logic [2:0]      md_funct3_o,
  output logic [6:0]      md_opcode_o,
  output logic [6:0]      md_funct7_o,
  input  logic [XLEN-1:0] md_result_i,

  output logic            busy_o
);

  localparam logic [6:0] OPCODE_R      = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  // Counter only ever holds (cycles - 1), so clog2(max) bits are enough.
  localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  if (MUL_CYCLES < 1) begin : g_bad_mul_cycles
    $error("muldiv_sched: MUL_CYCLES must be >= 1");
  end
  if (DIV_CYCLES < 1) begin : g_bad_div_cycles
    $error("muldiv_sched: DIV_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [CNT_W-1:0] cnt_q;
  logic             last_q;
  logic             owner_q;
  logic [XLEN-1:0]  op1_q;
  logic [XLEN-1:0]  op2_q;
  logic [2:0]       funct3_q;
  logic [XLEN-1:0]  result_q;

  logic             any_req;
  logic             grant_idx;
  logic             accept;
  logic             cnt_zero;
  logic             rsp_hs;
  logic [XLEN-1:0]  sel_op1;
  logic [XLEN-1:0]  sel_op2;
  logic [2:0]       sel_funct3;

  // ---------------------------------------------------------------------------
  // Arbitration: on a tie the requester that did not win last time is picked;
  // otherwise whichever one is valid. Reset suppresses the grant so that a
  // request presented together with reset is never taken.
  // ---------------------------------------------------------------------------
  assign any_req   = req0_valid_i | req1_valid_i;
  assign grant_idx = (req0_valid_i & req1_valid_i) ? ~last_q : req1_valid_i;
  assign accept    = (state_q == ST_IDLE) & any_req & ~rst_i;

  assign sel_op1    = grant_idx ? req1_op1_i    : req0_op1_i;
  assign sel_op2    = grant_idx ? req1_op2_i    : req0_op2_i;
  assign sel_funct3 = grant_idx ? req1_funct3_i : req0_funct3_i;

  assign cnt_zero = (cnt_q == '0);
  assign rsp_hs   = (state_q == ST_RESP) & (owner_q ? rsp1_ready_i : rsp0_ready_i);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    rsp0_valid_o = 1'b0;
    rsp1_valid_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req0_ready_o = accept & ~grant_idx;
        req1_ready_o = accept &  grant_idx;
        if (accept) begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_zero) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp0_valid_o = ~rst_i & ~owner_q;
        rsp1_valid_o = ~rst_i &  owner_q;
        if (rsp_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Capture, countdown and result registers. The capture registers only load
  // on the accept edge, which is what makes the md_* multicycle paths legal.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      funct3_q <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op1_q    <= sel_op1;
        op2_q    <= sel_op2;
        funct3_q <= sel_funct3;
        owner_q  <= grant_idx;
        last_q   <= grant_idx;
        cnt_q    <= sel_funct3[2] ? DIV_LOAD : MUL_LOAD;
      end else if ((state_q == ST_EXEC) && !cnt_zero) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if ((state_q == ST_EXEC) && cnt_zero) begin
        result_q <= md_result_i;
      end
    end
  end

  assign md_in1_o     = op1_q;
  assign md_in2_o     = op2_q;
  assign md_funct3_o  = funct3_q;
  assign md_opcode_o  = OPCODE_R;
  assign md_funct7_o  = FUNCT7_MULDIV;
  assign rsp_result_o = result_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule
